// File: rtl/iterative_multiplier.sv
// Sequential 32x32 shift-and-add multiplier, one multiplier bit per cycle, fixed 33-cycle latency.
// Define MULT_SIGNED_EN for two's-complement operands; the default build is unsigned.
module iterative_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        ready,
   output logic        done,
   output logic [63:0] product,
   output logic        overflow
);

   localparam int DATA_W = 32;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [PROD_W-1:0]   mcand_q, mcand_d;
   logic [DATA_W-1:0]   mplier_q, mplier_d;
   logic [PROD_W-1:0]   product_q, product_d;
   logic                ovf_q, ovf_d;
   logic [PROD_W-1:0]   acc_sum;
   logic [PROD_W-1:0]   result;

`ifdef MULT_SIGNED_EN
   logic                neg_q, neg_d;
   logic signed [DATA_W-1:0] a_s, b_s;

   assign a_s = signed'(a);
   assign b_s = signed'(b);

   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
      return v[DATA_W-1] ? (DATA_W'(~v) + DATA_W'(1)) : DATA_W'(v);
   endfunction

   function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] v, input logic neg);
      return neg ? (~v + PROD_W'(1)) : v;
   endfunction

   function automatic logic calc_ovf(input logic [PROD_W-1:0] p);
      return p[PROD_W-1:DATA_W] != {DATA_W{p[DATA_W-1]}};
   endfunction
`else
   function automatic logic calc_ovf(input logic [PROD_W-1:0] p);
      return p[PROD_W-1:DATA_W] != '0;
   endfunction
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      product_d = product_q;
      ovf_d     = ovf_q;
`ifdef MULT_SIGNED_EN
      neg_d     = neg_q;
`endif
      // Full-width add; the multiplicand has already been shifted into place.
      acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MULT_SIGNED_EN
      result    = apply_sign(acc_sum, neg_q);
`else
      result    = acc_sum;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = BUSY;
               cnt_d   = '0;
               acc_d   = '0;
`ifdef MULT_SIGNED_EN
               mcand_d  = {{DATA_W{1'b0}}, magnitude(a_s)};
               mplier_d = magnitude(b_s);
               neg_d    = a_s[DATA_W-1] ^ b_s[DATA_W-1];
`else
               mcand_d  = {{DATA_W{1'b0}}, a};
               mplier_d = b;
`endif
            end
         end
         BUSY: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d   = DONE;
               product_d = result;
               ovf_d     = calc_ovf(result);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         ovf_q     <= 1'b0;
`ifdef MULT_SIGNED_EN
         neg_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
`ifdef MULT_SIGNED_EN
         neg_q     <= neg_d;
`endif
      end
   end

   assign ready    = (state_q == IDLE);
   assign done     = (state_q == DONE);
   assign product  = product_q;
   assign overflow = ovf_q;

endmodule
